dpram_arbiter: RTL

DPRAM_ARBITER -- requirements
Module: dpram_arbiter

---
 rtl/dpram_arbiter_if.sv | 42 ++++
 rtl/dpram_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/dpram_arbiter_if.sv
// Bus bundle for the three-requester dpram arbiter.
// slave = arbiter side, master = requesters plus the RAM port.
interface dpram_arbiter_if #(
    parameter int ADRW = 8,
    parameter int DATW = 8
);
    logic            req0_valid, req1_valid, req2_valid;
    logic            req0_we,    req1_we,    req2_we;
    logic [ADRW-1:0] req0_addr,  req1_addr,  req2_addr;
    logic [DATW-1:0] req0_wdata, req1_wdata, req2_wdata;
    logic            req0_ready, req1_ready, req2_ready;
    logic            req0_rvalid, req1_rvalid, req2_rvalid;
    logic [DATW-1:0] req0_rdata, req1_rdata, req2_rdata;
    logic            ram_wren;
    logic [ADRW-1:0] ram_address;
    logic [DATW-1:0] ram_data;
    logic [DATW-1:0] ram_q;

    modport slave (
        input  req0_valid, req1_valid, req2_valid,
        input  req0_we, req1_we, req2_we,
        input  req0_addr, req1_addr, req2_addr,
        input  req0_wdata, req1_wdata, req2_wdata,
        output req0_ready, req1_ready, req2_ready,
        output req0_rvalid, req1_rvalid, req2_rvalid,
        output req0_rdata, req1_rdata, req2_rdata,
        output ram_wren, ram_address, ram_data,
        input  ram_q
    );

    modport master (
        output req0_valid, req1_valid, req2_valid,
        output req0_we, req1_we, req2_we,
        output req0_addr, req1_addr, req2_addr,
        output req0_wdata, req1_wdata, req2_wdata,
        input  req0_ready, req1_ready, req2_ready,
        input  req0_rvalid, req1_rvalid, req2_rvalid,
        input  req0_rdata, req1_rdata, req2_rdata,
        input  ram_wren, ram_address, ram_data,
        output ram_q
    );
endinterface

// File: rtl/dpram_arbiter.sv
// Round-robin share of one synchronous dpram port among three requesters.
// Reads return two cycles after acceptance through a tagged pipeline.
module dpram_arbiter #(
    parameter int ADRW = 8,
    parameter int DATW = 8
) (
    input  logic           clk,
    input  logic           reset,
    dpram_arbiter_if.slave bus
);
    logic [1:0]      last_q, last_d;
    logic            s1_v_q, s1_v_d;
    logic [1:0]      s1_tag_q, s1_tag_d;
    logic [2:0]      rvalid_q, rvalid_d;
    logic [DATW-1:0] rdata_q [3];
    logic [DATW-1:0] rdata_d [3];

    logic [2:0]      vld;
    logic [2:0]      we_a;
    logic [ADRW-1:0] addr_a [3];
    logic [DATW-1:0] wdata_a [3];
    logic [1:0]      idx0, idx1, idx2;
    logic            gnt_any;
    logic [1:0]      gnt_id;
    logic [2:0]      ready;

    function automatic logic [1:0] nxt(input logic [1:0] a);
        nxt = (a == 2'd2) ? 2'd0 : a + 2'd1;
    endfunction

    assign we_a       = {bus.req2_we, bus.req1_we, bus.req0_we};
    assign addr_a[0]  = bus.req0_addr;
    assign addr_a[1]  = bus.req1_addr;
    assign addr_a[2]  = bus.req2_addr;
    assign wdata_a[0] = bus.req0_wdata;
    assign wdata_a[1] = bus.req1_wdata;
    assign wdata_a[2] = bus.req2_wdata;

    // Reset masks every request so nothing reaches the RAM while held.
    always_comb begin
        vld = {bus.req2_valid, bus.req1_valid, bus.req0_valid} & {3{~reset}};
        idx0 = nxt(last_q);
        idx1 = nxt(idx0);
        idx2 = nxt(idx1);
        gnt_any = 1'b1;
        gnt_id  = idx0;
        if (vld[idx0])      gnt_id = idx0;
        else if (vld[idx1]) gnt_id = idx1;
        else if (vld[idx2]) gnt_id = idx2;
        else begin
            gnt_any = 1'b0;
            gnt_id  = 2'd0;
        end
        ready = gnt_any ? (3'b001 << gnt_id) : 3'b000;
    end

    assign bus.req0_ready  = ready[0];
    assign bus.req1_ready  = ready[1];
    assign bus.req2_ready  = ready[2];
    assign bus.ram_wren    = gnt_any & we_a[gnt_id];
    assign bus.ram_address = gnt_any ? addr_a[gnt_id] : '0;
    assign bus.ram_data    = gnt_any ? wdata_a[gnt_id] : '0;

    always_comb begin
        last_d   = gnt_any ? gnt_id : last_q;
        s1_v_d   = gnt_any & ~we_a[gnt_id];
        s1_tag_d = gnt_id;
        rvalid_d = 3'b000;
        rdata_d  = rdata_q;
        if (s1_v_q) begin
            rvalid_d[s1_tag_q] = 1'b1;
            rdata_d[s1_tag_q]  = bus.ram_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q   <= 2'd2;
            s1_v_q   <= 1'b0;
            s1_tag_q <= 2'd0;
            rvalid_q <= 3'b000;
            for (int i = 0; i < 3; i++) rdata_q[i] <= '0;
        end else begin
            last_q   <= last_d;
            s1_v_q   <= s1_v_d;
            s1_tag_q <= s1_tag_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.req0_rvalid = rvalid_q[0];
    assign bus.req1_rvalid = rvalid_q[1];
    assign bus.req2_rvalid = rvalid_q[2];
    assign bus.req0_rdata  = rdata_q[0];
    assign bus.req1_rdata  = rdata_q[1];
    assign bus.req2_rdata  = rdata_q[2];
endmodule
